// File: rtl/radiant_wb_cmd_master.sv
// radiant_wb_cmd_master: single-command Wishbone initiator with per-attempt timeout and bounded retry
module radiant_wb_cmd_master #(
   parameter int ADR_W     = 9,
   parameter int TIMEOUT   = 255,
   parameter int MAX_RETRY = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic             cmd_we_i,
   input  logic [ADR_W-1:0] cmd_adr_i,
   input  logic [31:0]      cmd_dat_i,
   input  logic [3:0]       cmd_sel_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [31:0]      rsp_dat_o,
   output logic [1:0]       rsp_status_o,
   output logic             wb_cyc_o,
   output logic             wb_stb_o,
   output logic             wb_we_o,
   output logic [ADR_W-1:0] wb_adr_o,
   output logic [31:0]      wb_dat_o,
   output logic [3:0]       wb_sel_o,
   input  logic [31:0]      wb_dat_i,
   input  logic             wb_ack_i,
   input  logic             wb_err_i,
   input  logic             wb_rty_i
);
   typedef enum logic [1:0] {IDLE, CYCLE, GAP, RESP} state_t;
   state_t      state;
   logic [15:0] tcnt;
   logic [3:0]  retries;
   logic        last_try, expired, finish;
   always_comb begin
      last_try = retries == 4'(MAX_RETRY);
      expired  = tcnt == 16'(TIMEOUT - 1);
      finish   = wb_ack_i || wb_err_i || (wb_rty_i && last_try) || (!wb_rty_i && expired);
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         tcnt         <= '0;
         retries      <= '0;
         cmd_ready_o  <= 1'b0;
         rsp_valid_o  <= 1'b0;
         rsp_dat_o    <= '0;
         rsp_status_o <= '0;
         wb_cyc_o     <= 1'b0;
         wb_stb_o     <= 1'b0;
         wb_we_o      <= 1'b0;
         wb_adr_o     <= '0;
         wb_dat_o     <= '0;
         wb_sel_o     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_ready_o && cmd_valid_i) begin
                  cmd_ready_o <= 1'b0;
                  wb_we_o     <= cmd_we_i;
                  wb_adr_o    <= cmd_adr_i;
                  wb_dat_o    <= cmd_dat_i;
                  wb_sel_o    <= cmd_sel_i;
                  retries     <= '0;
                  tcnt        <= '0;
                  wb_cyc_o    <= 1'b1;
                  wb_stb_o    <= 1'b1;
                  state       <= CYCLE;
               end else begin
                  cmd_ready_o <= 1'b1;
               end
            end
            CYCLE: begin
               // ack beats err beats rty beats timeout
               if (finish) begin
                  wb_cyc_o     <= 1'b0;
                  wb_stb_o     <= 1'b0;
                  rsp_valid_o  <= 1'b1;
                  rsp_status_o <= wb_ack_i ? 2'd0 : wb_err_i ? 2'd1 : wb_rty_i ? 2'd3 : 2'd2;
                  rsp_dat_o    <= (wb_ack_i && !wb_we_o) ? wb_dat_i : 32'd0;
                  state        <= RESP;
               end else if (wb_rty_i) begin
                  retries  <= retries + 4'd1;
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  state    <= GAP;
               end else begin
                  tcnt <= tcnt + 16'd1;
               end
            end
            GAP: begin
               tcnt     <= '0;
               wb_cyc_o <= 1'b1;
               wb_stb_o <= 1'b1;
               state    <= CYCLE;
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_radiant_wb_cmd_master.sv
// tb_radiant_wb_cmd_master: directed and randomized commands against a scripted Wishbone slave
module tb_radiant_wb_cmd_master;
   localparam int TIMEOUT = 255, MAX_RETRY = 3;
   localparam int K_SIL = 0, K_ACK = 1, K_ERR = 2, K_RTY = 3, K_AE = 4;
   logic        clk_i = 1'b0, rst_i = 1'b1;
   logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0;
   logic [8:0]  cmd_adr_i = '0, wb_adr_o;
   logic [31:0] cmd_dat_i = '0, rsp_dat_o, wb_dat_o, wb_dat_i = '0;
   logic [3:0]  cmd_sel_i = '0, wb_sel_o;
   logic        rsp_valid_o, rsp_ready_i = 1'b0;
   logic [1:0]  rsp_status_o;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
   int          vec = 0, errs = 0;
   int          kinds[8], dly[8];
   always #5 clk_i = ~clk_i;
   radiant_wb_cmd_master #(.ADR_W(9), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
      .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
      .rsp_status_o(rsp_status_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
      .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic quiet_slave();
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_rty_i = 1'b0;
   endtask
   // Slave follows kinds/dly per attempt; expectations come from a plain walk of the script.
   task automatic run_cmd(input logic we, input logic [8:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [31:0] rdat, input int hold);
      int exp_att, exp_st, r, n, att, hi, lo, bad, k;
      logic [31:0] exp_dat;
      bit done, fire;
      int exp_len[$], lens[$], gaps[$];
      exp_att = 0; exp_st = 0; exp_dat = '0; r = 0;
      for (int i = 0; i < 8; i++) begin
         exp_att++;
         if (kinds[i] == K_SIL) begin exp_len.push_back(TIMEOUT); exp_st = 2; break; end
         exp_len.push_back(dly[i] + 1);
         if (kinds[i] == K_ACK || kinds[i] == K_AE) begin exp_st = 0; exp_dat = we ? 32'd0 : rdat; break; end
         if (kinds[i] == K_ERR) begin exp_st = 1; break; end
         if (r < MAX_RETRY) r++;
         else begin exp_st = 3; break; end
      end
      @(negedge clk_i);
      cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
      n = 0;
      while (!cmd_ready_o && n < 20) begin @(negedge clk_i); n++; end
      chk("cmd_ready", cmd_ready_o, 1);
      @(negedge clk_i);
      cmd_valid_i = 1'b0; cmd_we_i = ~we; cmd_adr_i = $urandom; cmd_dat_i = $urandom; cmd_sel_i = $urandom;
      chk("cyc_latency", wb_cyc_o, 1);
      done = 0; att = 0; hi = 0; lo = 0; bad = 0;
      for (n = 0; n < 2000; n++) begin
         if (wb_cyc_o) begin
            if (hi == 0 && att > 0) gaps.push_back(lo);
            hi++; lo = 0;
            if (wb_stb_o !== 1'b1 || wb_we_o !== we || wb_adr_o !== adr || wb_dat_o !== dat || wb_sel_o !== sel) bad++;
            k = att < 8 ? kinds[att] : K_SIL;
            fire = k != K_SIL && hi == dly[att] + 1;
            wb_ack_i = fire && (k == K_ACK || k == K_AE);
            wb_err_i = fire && (k == K_ERR || k == K_AE);
            wb_rty_i = fire && k == K_RTY;
            wb_dat_i = fire ? rdat : $urandom;
         end else begin
            if (hi > 0) begin lens.push_back(hi); att++; hi = 0; end
            lo++;
            if (wb_stb_o !== 1'b0) bad++;
            {wb_ack_i, wb_err_i, wb_rty_i} = 3'($urandom);
            wb_dat_i = $urandom;
            if (rsp_valid_o) begin done = 1; break; end
         end
         @(negedge clk_i);
      end
      chk("rsp_seen", done, 1);
      chk("attempts", lens.size(), exp_att);
      for (int i = 0; i < lens.size() && i < exp_len.size(); i++) chk("cyc_len", lens[i], exp_len[i]);
      foreach (gaps[i]) chk("gap_len", gaps[i], 1);
      chk("status", rsp_status_o, exp_st);
      chk("rsp_dat", rsp_dat_o, exp_dat);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk_i);
         if (rsp_valid_o !== 1'b1 || rsp_dat_o !== exp_dat || rsp_status_o !== 2'(exp_st)) bad++;
      end
      chk("bus_and_hold", bad, 0);
      quiet_slave();
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      chk("rsp_drop", rsp_valid_o, 0);
      chk("ready_gap", cmd_ready_o, 0);
      @(negedge clk_i);
      chk("ready_back", cmd_ready_o, 1);
   endtask
   initial begin
      int n;
      logic [31:0] rd;
      kinds = '{default: K_SIL};
      dly = '{default: 0};
      repeat (2) @(negedge clk_i);
      chk("rst_cyc", wb_cyc_o, 0);
      chk("rst_stb", wb_stb_o, 0);
      chk("rst_ready", cmd_ready_o, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_bus", {wb_we_o, wb_adr_o, wb_sel_o, rsp_status_o}, 0);
      chk("rst_wdat", wb_dat_o, 0);
      chk("rst_rdat", rsp_dat_o, 0);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("ready_after_rst", cmd_ready_o, 1);
      kinds[0] = K_ACK; dly[0] = 3;
      run_cmd(1'b1, 9'h000, 32'h0000_0107, 4'hF, 32'hDEAD_BEEF, 0);
      kinds[0] = K_ACK; dly[0] = 1;
      run_cmd(1'b0, 9'h008, 32'h1234_5678, 4'hF, 32'h00AB_CDEF, 5);
      kinds[0] = K_SIL;
      run_cmd(1'b0, 9'h004, 32'h0, 4'hF, 32'h5555_AAAA, 1);
      kinds = '{K_RTY, K_RTY, K_RTY, K_RTY, K_ACK, K_ACK, K_ACK, K_ACK};
      dly = '{0, 2, 1, 0, 0, 0, 0, 0};
      run_cmd(1'b0, 9'h010, 32'h0, 4'h3, 32'h0BAD_F00D, 0);
      kinds = '{K_RTY, K_RTY, K_ACK, K_SIL, K_SIL, K_SIL, K_SIL, K_SIL};
      run_cmd(1'b0, 9'h014, 32'h0, 4'hC, 32'hCAFE_0001, 2);
      kinds[0] = K_AE; dly[0] = 0;
      run_cmd(1'b0, 9'h018, 32'h0, 4'hF, 32'h7777_1111, 0);
      kinds[0] = K_ERR; dly[0] = 2;
      run_cmd(1'b0, 9'h01C, 32'h0, 4'hF, 32'h7777_2222, 0);
      kinds[0] = K_SIL;
      @(negedge clk_i);
      cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 9'h020; cmd_dat_i = 32'h99; cmd_sel_i = 4'h1;
      n = 0;
      while (!cmd_ready_o && n < 20) begin @(negedge clk_i); n++; end
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("mid_cyc_before", wb_cyc_o, 1);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      chk("mid_rst_cyc", {wb_cyc_o, wb_stb_o}, 0);
      chk("mid_rst_rsp", rsp_valid_o, 0);
      n = 0;
      repeat (4) begin @(negedge clk_i); if (rsp_valid_o !== 1'b0 || wb_cyc_o !== 1'b0) n++; end
      chk("mid_rst_quiet", n, 0);
      kinds[0] = K_ACK; dly[0] = 0;
      run_cmd(1'b0, 9'h024, 32'h0, 4'hF, 32'h0042_4242, 0);
      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < 8; i++) begin
            kinds[i] = $urandom_range(K_ACK, K_AE);
            dly[i] = $urandom_range(0, 5);
         end
         if ($urandom_range(0, 9) == 0) kinds[$urandom_range(0, 3)] = K_SIL;
         rd = $urandom;
         run_cmd(1'($urandom), 9'($urandom), $urandom, 4'($urandom), rd, $urandom_range(0, 3));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
